// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the requantizing layer buffer.
package nn_pkg;

    typedef enum logic [0:0] {IDLE, DRAIN} rd_state_e;

    // Accumulator width produced by a bitserial layer with the given fan-in.
    function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned n_in);
        return 2 * data_w + $clog2(n_in);
    endfunction

    // Rounding arithmetic right shift then clamp to a signed data_w range.
    // The rounding constant behaves as it would in an (acc_bits+1)-bit adder,
    // so a constant landing on the sign bit turns negative and wider ones vanish.
    function automatic logic signed [63:0] sat_round(
        input  logic signed [63:0] val,
        input  int unsigned        shift,
        input  int unsigned        data_w,
        input  int unsigned        acc_bits,
        output logic               sat
    );
        logic signed [63:0] rnd;
        logic signed [63:0] sum;
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic signed [63:0] res;
        rnd = '0;
        if (shift > 0 && shift - 1 < acc_bits) begin
            rnd = 64'sd1 <<< (shift - 1);
        end else if (shift > 0 && shift - 1 == acc_bits) begin
            rnd = -(64'sd1 <<< acc_bits);
        end
        sum     = val + rnd;
        shifted = sum >>> shift;
        max_v   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (data_w - 1));
        sat     = 1'b0;
        res     = shifted;
        if (shifted > max_v) begin
            sat = 1'b1;
            res = max_v;
        end else if (shifted < min_v) begin
            sat = 1'b1;
            res = min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/nn_requant_unit.sv
// Registered round + saturate stage: one accumulator in, one DATA_W activation out.
module nn_requant_unit
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ACC_W   = 39,
    parameter int unsigned SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ACC_W-1:0]   in_data,
    input  logic               in_valid,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_sat
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sat_q, sat_d;
    logic signed [63:0] ext;
    logic signed [63:0] res;
    logic               sat_c;

    always_comb begin
        ext     = {{(64 - ACC_W){in_data[ACC_W-1]}}, in_data};
        sat_c   = 1'b0;
        res     = sat_round(ext, 32'(shift), DATA_W, ACC_W, sat_c);
        data_d  = DATA_W'(res);
        valid_d = in_valid;
        sat_d   = in_valid & sat_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_sat   = sat_q;

endmodule

// File: rtl/nn_requant_buffer.sv
// Requantize an accumulator stream into a ping-pong frame store and replay it as valid/ready.
// Optional per-frame argmax tracking is enabled by defining NN_REQUANT_ARGMAX_EN.
module nn_requant_buffer
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned N_ELEM  = 64,
    parameter int unsigned N_IN_UP = 128,
    parameter int unsigned ACC_W   = acc_w(DATA_W, N_IN_UP),
    parameter int unsigned SHIFT_W = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ACC_W-1:0]          in_data,
    input  logic                      in_valid,
    input  logic [SHIFT_W-1:0]        shift_amt,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      overrun,
    output logic                      sat_seen,
    output logic [$clog2(N_ELEM)-1:0] argmax_idx,
    output logic                      argmax_valid
);

    localparam int unsigned IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    logic [IDX_W-1:0]   in_cnt_q, in_cnt_d;
    logic [SHIFT_W-1:0] shift_q, shift_d, shift_eff;
    logic [DATA_W-1:0]  rq_data;
    logic               rq_valid, rq_sat;

    logic [1:0]         full_q, full_d, full_set, full_clr;
    logic               fill_bank_q, fill_bank_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               overrun_q, overrun_d;
    logic               sat_seen_q, sat_seen_d;
    logic               we;
    logic [DATA_W-1:0]  mem_q [2][N_ELEM];

    rd_state_e          state_q, state_d;
    logic               rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               rd_load, rd_bank_sel;
    logic [IDX_W-1:0]   rd_ptr_sel;

    // The shift is captured by input count, since the write pointer lags by the pipeline.
    always_comb begin
        in_cnt_d  = in_cnt_q;
        shift_d   = shift_q;
        shift_eff = (in_cnt_q == '0) ? shift_amt : shift_q;
        if (in_valid) begin
            shift_d  = shift_eff;
            in_cnt_d = (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + 1'b1;
        end
    end

    nn_requant_unit #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_requant (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .shift     (shift_eff),
        .out_data  (rq_data),
        .out_valid (rq_valid),
        .out_sat   (rq_sat)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        fill_bank_d = fill_bank_q;
        full_set    = '0;
        overrun_d   = overrun_q;
        sat_seen_d  = sat_seen_q;
        we          = 1'b0;
        if (rq_valid) begin
            if (rq_sat) begin
                sat_seen_d = 1'b1;
            end
            if (full_q[fill_bank_q]) begin
                overrun_d = 1'b1;
            end else begin
                we = 1'b1;
                if (wr_ptr_q == LAST_IDX) begin
                    full_set[fill_bank_q] = 1'b1;
                    fill_bank_d           = ~fill_bank_q;
                    wr_ptr_d              = '0;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[fill_bank_q][wr_ptr_q] <= rq_data;
        end
    end

    // The output register doubles as the read register: it is loaded with the next element.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        full_clr    = '0;
        rd_load     = 1'b0;
        rd_bank_sel = rd_bank_q;
        rd_ptr_sel  = '0;
        rd_ptr_inc  = rd_ptr_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_last_d  = (LAST_IDX == '0);
                    rd_load     = 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (rd_ptr_q == LAST_IDX) begin
                        full_clr[rd_bank_q] = 1'b1;
                        rd_bank_d           = ~rd_bank_q;
                        rd_ptr_d            = '0;
                        if (full_q[~rd_bank_q]) begin
                            rd_load     = 1'b1;
                            rd_bank_sel = ~rd_bank_q;
                            out_last_d  = (LAST_IDX == '0);
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end
                    end else begin
                        rd_ptr_d   = rd_ptr_inc;
                        rd_ptr_sel = rd_ptr_inc;
                        rd_load    = 1'b1;
                        out_last_d = (rd_ptr_inc == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        out_data_d = rd_load ? mem_q[rd_bank_sel][rd_ptr_sel] : out_data_q;
        full_d     = (full_q | full_set) & ~full_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q    <= '0;
            shift_q     <= '0;
            full_q      <= '0;
            fill_bank_q <= 1'b0;
            wr_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            sat_seen_q  <= 1'b0;
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            in_cnt_q    <= in_cnt_d;
            shift_q     <= shift_d;
            full_q      <= full_d;
            fill_bank_q <= fill_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            overrun_q   <= overrun_d;
            sat_seen_q  <= sat_seen_d;
            state_q     <= state_d;
            rd_bank_q   <= rd_bank_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overrun   = overrun_q;
    assign sat_seen  = sat_seen_q;

`ifdef NN_REQUANT_ARGMAX_EN
    logic signed [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]         max_idx_q, max_idx_d;
    logic [IDX_W-1:0]         am_idx_q, am_idx_d;
    logic                     am_valid_q, am_valid_d;
    logic                     new_max;

    // Strict compare keeps the earliest index on ties.
    always_comb begin
        max_d      = max_q;
        max_idx_d  = max_idx_q;
        am_idx_d   = am_idx_q;
        am_valid_d = 1'b0;
        new_max    = (wr_ptr_q == '0) || ($signed(rq_data) > max_q);
        if (we) begin
            if (new_max) begin
                max_d     = $signed(rq_data);
                max_idx_d = wr_ptr_q;
            end
            if (wr_ptr_q == LAST_IDX) begin
                am_valid_d = 1'b1;
                am_idx_d   = new_max ? wr_ptr_q : max_idx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q      <= '0;
            max_idx_q  <= '0;
            am_idx_q   <= '0;
            am_valid_q <= 1'b0;
        end else begin
            max_q      <= max_d;
            max_idx_q  <= max_idx_d;
            am_idx_q   <= am_idx_d;
            am_valid_q <= am_valid_d;
        end
    end

    assign argmax_idx   = am_idx_q;
    assign argmax_valid = am_valid_q;
`else
    assign argmax_idx   = '0;
    assign argmax_valid = 1'b0;
`endif

endmodule

// File: doc/nn_requant_buffer.md
Name: nn_requant_buffer

Overview:
- Downstream of bitserial_nn; consumes its per-neuron accumulator stream (out_data/out_valid, post-ReLU, ACC_W signed).
- Requantizes each value to DATA_W by rounding right-shift plus saturation.
- Collects one full layer of N_ELEM values in a double-buffered (ping-pong) store.
- Replays each completed layer as a valid/ready stream sized to feed the data_in port of the next bitserial_nn layer.

Parameters:
- DATA_W, 16, output activation width (signed)
- N_ELEM, 64, values per layer frame (= upstream N_HIDDEN)
- N_IN_UP, 128, upstream fan-in; sets ACC_W
- ACC_W, 2*DATA_W+$clog2(N_IN_UP), input accumulator width (signed)
- SHIFT_W, 6, width of shift-amount input

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_data  in  ACC_W  signed accumulator value from upstream
- in_valid  in  1  one-cycle strobe per value; no backpressure possible
- shift_amt  in  SHIFT_W  right-shift amount; sampled on first element of each frame
- out_data  out  DATA_W  signed requantized activation
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  marks element N_ELEM-1 of a frame
- overrun  out  1  sticky: input dropped because both banks were full
- sat_seen  out  1  sticky: at least one value saturated since reset
- argmax_idx  out  $clog2(N_ELEM)  index of frame maximum (see Optional Feature)
- argmax_valid  out  1  one-cycle pulse with argmax_idx

Behaviour:
- Reset (asynchronous, any state): all outputs 0; both banks marked empty; write and read pointers 0; fill bank = 0.
- Requantization, stage 1, registered:
  - s = shift_amt latched at frame start.
  - r = (in_data + (s>0 ? 1<<(s-1) : 0)) >>> s, computed at ACC_W+1 bits.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; sat_seen set on clamp.
- Write stage 2: result written to fill bank at wr_ptr, wr_ptr++.
  - On wr_ptr == N_ELEM-1: fill bank marked full, fill bank toggles, wr_ptr = 0.
  - Latency from in_valid to element stored: 2 cycles.
- Input arrives while the target fill bank is still full (not drained): value dropped, overrun = 1 (sticky until reset), wr_ptr unchanged.
- Read FSM:
  - IDLE → DRAIN when the read bank is full.
  - DRAIN: out_valid = 1, out_data = bank[rd_ptr] (registered read, 1-cycle prefetch); data held stable while out_valid & !out_ready.
  - On handshake: rd_ptr++; out_last = (rd_ptr == N_ELEM-1).
  - Handshake on last element: bank marked empty, read bank toggles, rd_ptr = 0; go to DRAIN if the other bank is full, else IDLE.
  - No bubble between back-to-back frames.
- Simultaneous events:
  - Write finishing a bank and drain finishing the other bank in the same cycle: both take effect.
  - A freeing bank becomes writable the next cycle.
- out_valid never deasserts without a handshake, except on reset.

Optional Feature:
- Macro NN_REQUANT_ARGMAX_EN.
- Defined:
  - Running max over saturated values of each frame during fill; ties resolve to the lowest index.
  - argmax_idx updated and argmax_valid pulsed for one cycle, 1 cycle after the frame's last element is written.
- Undefined: argmax_idx and argmax_valid tied to 0; no comparator logic.
- Ports are present in both cases.

Decomposition:
- Package nn_pkg:
  - ACC_W calculation function
  - Saturate/round function (sat_round)
  - Read-FSM state enum {IDLE, DRAIN}
- Sub-module nn_requant_unit: registered round+saturate stage with a sat flag; reused by other layers.

Test Plan:
- DATA_W=16, shift 8, in_data 1000 → out 4; in_data 1151 → 4; in_data 1152 → 5; shift 0, in_data 7 → 7.
- shift 0, in_data 2^30 → out 32767, sat_seen = 1; in_data −2^30 → −32768.
- 64 values 0..63 (shift 0), out_ready = 1 → 64 outputs 0..63, out_last only on 63, no gaps.
- out_ready toggling 1/0 every cycle → out_data stable while stalled; sequence intact; 3 back-to-back frames fully delivered.
- out_ready = 0, feed 3 frames → first two stored; every input of the third frame dropped and overrun = 1; after release, exactly 128 outputs.
- rst_n low mid-drain at element 20 → out_valid = 0 immediately; a new frame after reset starts at index 0.
- With NN_REQUANT_ARGMAX_EN: frame max 500 at indices 10 and 40 → argmax_idx = 10, single-cycle argmax_valid.
